serial_subtractor: RTL and testbench

- Parametrised bit-serial two's-complement subtractor computing diff = a - b - bin over WIDTH bits.
- Processes one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- Trades latency for area; it is the multi-bit, sequential successor to the team's 1-bit full subtractor.
- Used where wide subtractions are infrequent and area matters; start/busy/done control.

---
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Start/busy/done handshake; results are held between completions.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, sr, sr_nx;
    logic [CW-1:0]    cnt;
    logic             br, br_nx, d;
    logic             a_msb, b_msb;
    logic             accept, last;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Single full-subtractor cell; the result enters from the MSB side so
    // after WIDTH shifts bit 0 of the operands has landed in sr[0].
    always_comb begin
        accept = start && (state != RUN);
        last   = (cnt == LAST);
        d      = sa[0] ^ sb[0] ^ br;
        br_nx  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sr_nx  = sr >> 1;
        sr_nx[WIDTH-1] = d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            sa    <= a;
            sb    <= b;
            sr    <= '0;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= sr_nx;
            br  <= br_nx;
            cnt <= cnt + CW'(1);
            // On the last bit, d is the result MSB and br_nx the final borrow.
            if (last) begin
                diff <= sr_nx;
                bout <= br_nx;
                ovf  <= (a_msb != b_msb) && (d != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances checked every cycle against
// an arithmetic latency model, plus directed literal cases and randomized traffic.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rn;
    logic       st8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       st1, a1, b1, bin1, busy1, done1, diff1, bout1, ovf1;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    int          k[2]  = '{0, 0};
    logic [63:0] pd[2] = '{64'd0, 64'd0};
    logic [63:0] ed[2] = '{64'd0, 64'd0};
    logic        pb[2] = '{1'b0, 1'b0};
    logic        po[2] = '{1'b0, 1'b0};
    logic        eb[2] = '{1'b0, 1'b0};
    logic        eo[2] = '{1'b0, 1'b0};

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rn), .start(st8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rn), .start(st1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Returns {ovf, bout, diff} for a w-bit subtraction.
    function automatic logic [65:0] calc(input int w, input logic [63:0] av, input logic [63:0] bv,
                                         input logic bi);
        logic [63:0] m, dv;
        logic [64:0] f;
        logic        am, bm, dm;
        m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        f  = {1'b0, av & m} - {1'b0, bv & m} - 65'(bi);
        dv = f[63:0] & m;
        am = av[w-1];
        bm = bv[w-1];
        dm = dv[w-1];
        return {(am != bm) && (dm != am), f[64], dv};
    endfunction

    // k = cycles since acceptance: 1..w busy, w+1 done, 0 idle.
    task automatic model_step(input int i, input int w, input logic s, input logic [63:0] av,
                              input logic [63:0] bv, input logic bi);
        logic [65:0] r;
        if (!rn) begin
            k[i] = 0; ed[i] = '0; eb[i] = 1'b0; eo[i] = 1'b0;
        end else if (s && !(k[i] >= 1 && k[i] <= w)) begin
            r = calc(w, av, bv, bi);
            pd[i] = r[63:0]; pb[i] = r[64]; po[i] = r[65];
            k[i] = 1;
        end else if (k[i] >= 1 && k[i] <= w) begin
            k[i]++;
            if (k[i] == w + 1) begin
                ed[i] = pd[i]; eb[i] = pb[i]; eo[i] = po[i];
            end
        end else begin
            k[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 8, st8, 64'(a8), 64'(b8), bin8);
        model_step(1, 1, st1, 64'(a1), 64'(b1), bin1);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("busy8", 64'(busy8), 64'(k[0] >= 1 && k[0] <= 8));
            check("done8", 64'(done8), 64'(k[0] == 9));
            check("diff8", 64'(diff8), ed[0]);
            check("bout8", 64'(bout8), 64'(eb[0]));
            check("ovf8",  64'(ovf8),  64'(eo[0]));
            check("busy1", 64'(busy1), 64'(k[1] == 1));
            check("done1", 64'(done1), 64'(k[1] == 2));
            check("diff1", 64'(diff1), ed[1]);
            check("bout1", 64'(bout1), 64'(eb[1]));
            check("ovf1",  64'(ovf1),  64'(eo[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done8(output int nb);
        int n;
        nb = 0;
        n  = 0;
        while (!done8 && n < 20) begin
            if (busy8) nb++;
            tick();
            n++;
        end
        check("done8_seen", 64'(done8), 64'd1);
    endtask

    task automatic op8(input string nm, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input logic [7:0] xd, input logic xb, input logic xo);
        int nb;
        st8 = 1'b1; a8 = av; b8 = bv; bin8 = bi;
        tick();
        st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        wait_done8(nb);
        check({nm, "_busycycles"}, 64'(nb), 64'd8);
        check({nm, "_diff"}, 64'(diff8), 64'(xd));
        check({nm, "_bout"}, 64'(bout8), 64'(xb));
        check({nm, "_ovf"},  64'(ovf8),  64'(xo));
    endtask

    initial begin
        int nb, ndone;
        logic [2:0] v;
        logic [7:0] btbl;

        rn = 1'b0; st8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        st1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        tick();
        chk_on = 1'b1;
        tick();
        rn = 1'b1;
        tick();
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_diff", 64'(diff8), 64'd0);

        op8("sub5_3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        tick();
        op8("sub3_5", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        tick();
        op8("bin_only", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        tick();
        op8("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        tick();
        op8("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        tick();

        // start pulsed mid-run must not disturb the running operation
        st8 = 1'b1; a8 = 8'h40; b8 = 8'h11; bin8 = 1'b0;
        tick();
        st8 = 1'b0;
        tick(); tick();
        st8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
        tick();
        st8 = 1'b0;
        wait_done8(nb);
        check("ignore_diff", 64'(diff8), 64'h2F);
        check("ignore_bout", 64'(bout8), 64'd0);
        tick();

        // back-to-back: start held through DONE
        op8("b2b_first", 8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0);
        st8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
        tick();
        check("b2b_busy", 64'(busy8), 64'd1);
        check("b2b_done", 64'(done8), 64'd0);
        st8 = 1'b0;
        wait_done8(nb);
        check("b2b_busycycles", 64'(nb), 64'd8);
        check("b2b_diff", 64'(diff8), 64'h0F);
        tick();

        // reset in the middle of a run
        st8 = 1'b1; a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0;
        tick();
        st8 = 1'b0;
        tick(); tick(); tick();
        rn = 1'b0;
        tick();
        rn = 1'b1;
        check("midrst_busy", 64'(busy8), 64'd0);
        check("midrst_done", 64'(done8), 64'd0);
        check("midrst_diff", 64'(diff8), 64'd0);
        check("midrst_bout", 64'(bout8), 64'd0);
        check("midrst_ovf",  64'(ovf8),  64'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) ndone++;
            tick();
        end
        check("midrst_no_activity", 64'(ndone), 64'd0);
        op8("after_rst", 8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0);
        tick();

        // WIDTH=1 exhaustive full-subtractor table; index = {a,b,bin}
        btbl = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; bin1 = v[0]; st1 = 1'b1;
            tick();
            st1 = 1'b0;
            check("w1_busy", 64'(busy1), 64'd1);
            check("w1_notdone", 64'(done1), 64'd0);
            tick();
            check("w1_done", 64'(done1), 64'd1);
            check("w1_diff", 64'(diff1), 64'(v[2] ^ v[1] ^ v[0]));
            check("w1_bout", 64'(bout1), 64'(btbl[v]));
            tick();
        end

        // randomized traffic on both instances, with occasional resets
        for (int i = 0; i < 400; i++) begin
            rn   = ($urandom % 120) != 0;
            st8  = ($urandom % 4) == 0;
            a8   = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            st1  = ($urandom % 2) == 0;
            a1   = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
            tick();
        end
        rn = 1'b1; st8 = 1'b0; st1 = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
